// File: rtl/rx_data_controller.sv
// Receive-side data controller: strips idle blocks, turns separator blocks into
// frame ends and packs per-lane 66-bit block payloads into one AXI4-Stream beat.
module rx_data_controller #(
    parameter int LANES      = 4,
    parameter int LANE_SEL_W = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  single_lane,
    input  logic [LANE_SEL_W-1:0] lane_select,
    input  logic                  channel_up,
    input  logic                  rx_valid,
    input  logic [2*LANES-1:0]    rx_header,
    input  logic [64*LANES-1:0]   rx_data,
    output logic                  m_axi_valid,
    output logic                  m_axi_last,
    output logic [64*LANES-1:0]   m_axi_data,
    output logic [8*LANES-1:0]    m_axi_keep,
    output logic                  frame_err,
    output logic [15:0]           err_cnt
);

    typedef enum logic [1:0] {
        NOT_UP,
        IDLE,
        IN_FRAME
    } state_e;

    localparam logic [1:0] HDR_DATA  = 2'b01;
    localparam logic [1:0] HDR_CTRL  = 2'b10;
    localparam logic [7:0] TYPE_IDLE = 8'h78;
    localparam logic [7:0] TYPE_SEP  = 8'h1E;
    localparam logic [7:0] TYPE_SEP7 = 8'hE1;

    state_e                state_q, state_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic [64*LANES-1:0]   data_q, data_d;
    logic [8*LANES-1:0]    keep_q, keep_d;
    logic                  err_q, err_d;
    logic [15:0]           err_cnt_q, err_cnt_d;

    always_comb begin : next_beat
        logic       in_frame;
        logic       ended;
        int         lane;
        int         cnt;
        logic [1:0] hdr;
        logic [63:0] blk;
        logic [7:0] slot_keep;

        // NOTE: every variable gets a default before any branch; a path that skips
        // an assignment would otherwise make synthesis infer a latch.
        state_d   = state_q;
        last_d    = 1'b0;
        err_d     = 1'b0;
        keep_d    = '0;
        data_d    = '0;
        in_frame  = (state_q == IN_FRAME);
        ended     = 1'b0;
        lane      = 0;
        cnt       = 0;
        hdr       = '0;
        blk       = '0;
        slot_keep = '0;

        if (!channel_up) begin
            state_d = NOT_UP;
            // Losing the channel mid-frame closes the frame with an empty aborting beat.
            if (state_q == IN_FRAME) begin
                last_d = 1'b1;
                err_d  = 1'b1;
            end
        end else if (rx_valid) begin
            for (int s = 0; s < LANES; s++) begin
                lane      = single_lane ? int'(lane_select) : s;
                slot_keep = '0;
                if ((s == 0 || !single_lane) && lane < LANES) begin
                    hdr = rx_header[2*lane +: 2];
                    blk = rx_data[64*lane +: 64];
                    if (hdr == HDR_DATA) begin
                        if (ended) begin
                            err_d = 1'b1;
                        end else begin
                            slot_keep = 8'hFF;
                            in_frame  = 1'b1;
                        end
                    end else if (hdr == HDR_CTRL) begin
                        case (blk[63:56])
                            TYPE_IDLE: begin
                            end
                            TYPE_SEP: begin
                                if (ended) begin
                                    err_d = 1'b1;
                                end else begin
                                    cnt = int'(blk[55:48]);
                                    if (cnt > 6) begin
                                        err_d = 1'b1;
                                        cnt   = 6;
                                    end
                                    for (int b = 0; b < 8; b++) slot_keep[b] = (b < cnt);
                                    // An empty separator outside a frame carries nothing to end.
                                    if (in_frame || cnt != 0) begin
                                        last_d = 1'b1;
                                        ended  = 1'b1;
                                    end
                                    in_frame = 1'b0;
                                end
                            end
                            TYPE_SEP7: begin
                                if (ended) begin
                                    err_d = 1'b1;
                                end else begin
                                    slot_keep = 8'h7F;
                                    last_d    = 1'b1;
                                    ended     = 1'b1;
                                    in_frame  = 1'b0;
                                end
                            end
                            default: err_d = 1'b1;
                        endcase
                    end else begin
                        err_d = 1'b1;
                    end
                    for (int b = 0; b < 8; b++) begin
                        data_d[64*s + 8*b +: 8] = slot_keep[b] ? blk[8*b +: 8] : 8'h00;
                    end
                    keep_d[8*s +: 8] = slot_keep;
                end
            end
            state_d = in_frame ? IN_FRAME : IDLE;
        end else if (state_q == NOT_UP) begin
            state_d = IDLE;
        end

        valid_d   = (|keep_d) || last_d;
        err_cnt_d = (err_d && err_cnt_q != 16'hFFFF) ? err_cnt_q + 16'd1 : err_cnt_q;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= NOT_UP;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            data_q    <= '0;
            keep_q    <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            data_q    <= data_d;
            keep_q    <= keep_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign m_axi_valid = valid_q;
    assign m_axi_last  = last_q;
    assign m_axi_data  = data_q;
    assign m_axi_keep  = keep_q;
    assign frame_err   = err_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_rx_data_controller.sv
// Scoreboard bench for rx_data_controller (LANES=4): each driven cycle pushes its
// expected beat, which is popped and compared one clock later.
module tb_rx_data_controller;

    localparam int LANES = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                single_lane;
    logic [1:0]          lane_select;
    logic                channel_up;
    logic                rx_valid;
    logic [2*LANES-1:0]  rx_header;
    logic [64*LANES-1:0] rx_data;
    logic                m_axi_valid;
    logic                m_axi_last;
    logic [64*LANES-1:0] m_axi_data;
    logic [8*LANES-1:0]  m_axi_keep;
    logic                frame_err;
    logic [15:0]         err_cnt;

    rx_data_controller #(.LANES(LANES)) dut (
        .clk(clk), .rst(rst), .single_lane(single_lane), .lane_select(lane_select),
        .channel_up(channel_up), .rx_valid(rx_valid), .rx_header(rx_header), .rx_data(rx_data),
        .m_axi_valid(m_axi_valid), .m_axi_last(m_axi_last), .m_axi_data(m_axi_data),
        .m_axi_keep(m_axi_keep), .frame_err(frame_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          v;
        logic          l;
        logic          e;
        logic [31:0]   k;
        logic [255:0]  d;
        logic [15:0]   c;
    } beat_t;

    beat_t       sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [15:0] exp_cnt  = 16'h0;

    localparam logic [63:0] DA   = 64'hA1A2_A3A4_A5A6_A7A8;
    localparam logic [63:0] DB   = 64'hB1B2_B3B4_B5B6_B7B8;
    localparam logic [63:0] GARB = 64'hDEAD_BEEF_0BAD_F00D;
    localparam logic [255:0] D4  = {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}};

    function automatic logic [63:0] ctl(input logic [7:0] t, input logic [7:0] c);
        return {t, c, 48'h8877_6655_4433};
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_beat(input logic l, input logic e, input logic [31:0] k,
                               input logic [255:0] d);
        beat_t b;
        if (e && exp_cnt != 16'hFFFF) exp_cnt++;
        b.v = (|k) || l;
        b.l = l;
        b.e = e;
        b.k = k;
        b.d = d;
        b.c = exp_cnt;
        sb.push_back(b);
    endtask

    task automatic step(input logic r, input logic cu, input logic rv, input logic sl,
                        input logic [1:0] ls, input logic [7:0] hdr, input logic [255:0] dat);
        beat_t b;
        rst         = r;
        channel_up  = cu;
        rx_valid    = rv;
        single_lane = sl;
        lane_select = ls;
        rx_header   = hdr;
        rx_data     = dat;
        @(posedge clk);
        #1;
        check("sb_depth", 256'(sb.size()), 256'd1);
        if (sb.size() != 0) begin
            b = sb.pop_front();
            check("valid",   256'(m_axi_valid), 256'(b.v));
            check("last",    256'(m_axi_last),  256'(b.l));
            check("keep",    256'(m_axi_keep),  256'(b.k));
            check("data",    m_axi_data,        b.d);
            check("err",     256'(frame_err),   256'(b.e));
            check("err_cnt", 256'(err_cnt),     256'(b.c));
        end
    endtask

    localparam logic [63:0]  IDL  = 64'h7800_8877_6655_4433;
    localparam logic [255:0] IDL3 = {IDL, IDL, IDL};

    initial begin
        // Reset, then blocks while channel is down must be dropped.
        exp_cnt = 16'h0;
        expect_beat(0, 0, 32'h0, '0);
        step(1, 0, 1, 0, 0, 8'h55, D4);
        expect_beat(0, 0, 32'h0, '0);
        step(0, 0, 1, 0, 0, 8'h55, D4);

        // Four data lanes, then a 3-byte separator; processed from the first channel_up cycle.
        expect_beat(0, 0, 32'hFFFF_FFFF, D4);
        step(0, 1, 1, 0, 0, 8'h55, D4);
        expect_beat(1, 0, 32'h0000_0007, {192'h0, 64'h0000_0000_0055_4433});
        step(0, 1, 1, 0, 0, 8'hAA, {IDL3, ctl(8'h1E, 8'd3)});

        // Single-lane on lane 2 with garbage headers elsewhere.
        expect_beat(0, 0, 32'h0000_00FF, {192'h0, 64'hCAFE_F00D_1234_5678});
        step(0, 1, 1, 1, 2, 8'h10, {GARB, 64'hCAFE_F00D_1234_5678, GARB, GARB});
        expect_beat(1, 0, 32'h0000_007F, {192'h0, 64'h0099_8877_6655_4433});
        step(0, 1, 1, 1, 2, 8'h20, {GARB, ctl(8'hE1, 8'h99), GARB, GARB});

        // Data, empty separator, then data after the frame end is discarded.
        expect_beat(1, 1, 32'h0000_00FF, {192'h0, DA});
        step(0, 1, 1, 0, 0, 8'h99, {IDL, DB, ctl(8'h1E, 8'd0), DA});
        // Empty separator between frames is a no-op.
        expect_beat(0, 0, 32'h0, '0);
        step(0, 1, 1, 0, 0, 8'hAA, {IDL3, ctl(8'h1E, 8'd0)});
        // Idle mid-frame gives sparse keep; over-long separator count clamps to 6.
        expect_beat(0, 0, 32'h00FF_00FF, {64'h0, DB, 64'h0, DA});
        step(0, 1, 1, 0, 0, 8'h99, {IDL, DB, IDL, DA});
        expect_beat(1, 1, 32'h0000_003F, {192'h0, 64'h0000_8877_6655_4433});
        step(0, 1, 1, 0, 0, 8'hAA, {IDL3, ctl(8'h1E, 8'd9)});

        // Channel drop after two data beats aborts the frame, then silence.
        expect_beat(0, 0, 32'hFFFF_FFFF, D4);
        step(0, 1, 1, 0, 0, 8'h55, D4);
        expect_beat(0, 0, 32'hFFFF_FFFF, D4);
        step(0, 1, 1, 0, 0, 8'h55, D4);
        expect_beat(1, 1, 32'h0, '0);
        step(0, 0, 1, 0, 0, 8'h55, D4);
        for (int i = 0; i < 3; i++) begin
            expect_beat(0, 0, 32'h0, '0);
            step(0, 0, 1, 0, 0, 8'h55, D4);
        end
        expect_beat(0, 0, 32'h0, '0);
        step(0, 1, 1, 0, 0, 8'hAA, {IDL3, IDL});

        // rx_valid gap keeps IN_FRAME: an empty separator afterwards still ends the frame.
        expect_beat(0, 0, 32'hFFFF_FFFF, D4);
        step(0, 1, 1, 0, 0, 8'h55, D4);
        expect_beat(0, 0, 32'h0, '0);
        step(0, 1, 0, 0, 0, 8'h55, D4);
        expect_beat(1, 0, 32'h0, '0);
        step(0, 1, 1, 0, 0, 8'hAA, {IDL3, ctl(8'h1E, 8'd0)});

        // rst mid-frame drops the frame silently and clears the error count.
        expect_beat(0, 0, 32'hFFFF_FFFF, D4);
        step(0, 1, 1, 0, 0, 8'h55, D4);
        exp_cnt = 16'h0;
        expect_beat(0, 0, 32'h0, '0);
        step(1, 1, 1, 0, 0, 8'h55, D4);
        expect_beat(0, 0, 32'h0, '0);
        step(0, 1, 1, 0, 0, 8'hAA, {IDL3, ctl(8'h1E, 8'd0)});

        // Bad control type / bad header inside a frame until err_cnt saturates.
        expect_beat(0, 0, 32'hFFFF_FFFF, D4);
        step(0, 1, 1, 0, 0, 8'h55, D4);
        for (int i = 0; i < 70000; i++) begin
            expect_beat(0, 1, 32'h0, '0);
            if (i % 2 == 0) step(0, 1, 1, 0, 0, 8'hAA, {IDL3, ctl(8'h55, 8'h00)});
            else            step(0, 1, 1, 0, 0, 8'hAB, {IDL3, DA});
        end
        check("err_cnt_sat", 256'(err_cnt), 256'(16'hFFFF));
        expect_beat(1, 0, 32'h0, '0);
        step(0, 1, 1, 0, 0, 8'hAA, {IDL3, ctl(8'h1E, 8'd0)});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
